ps2_key_ctrl: RTL



---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_scan2ascii.sv | 61 ++++++
 rtl/ps2_key_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared declarations for the PS/2 key controller slice:
//   - ps2_state_e : drain FSM states (IDLE -> ACK -> GAP -> IDLE)
//   - PS2_BREAK   : set-2 break prefix byte (F0)
//   - PS2_EXT     : set-2 extended prefix byte (E0)
//   - CNT_W_DEF   : default width of the press counter
// ----------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      GAP  = 2'd2
   } ps2_state_e;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam int         CNT_W_DEF = 8;

endpackage

// File: rtl/ps2_scan2ascii.sv
// ----------------------------------------------------------------------------
// ps2_scan2ascii
// Combinational scan-code set 2 to ASCII lookup for lowercase letters,
// digits and space. Any other code maps to 8'h00.
// Compiled only when PS2_ASCII_EN is defined.
// Ports:
//   code_i  : set-2 scan code (make code, no prefixes)
//   ascii_o : ASCII character, 8'h00 when unmapped
// ----------------------------------------------------------------------------
`ifdef PS2_ASCII_EN
module ps2_scan2ascii (
   input  logic [7:0] code_i,
   output logic [7:0] ascii_o
);

   always_comb begin
      ascii_o = 8'h00;
      case (code_i)
         8'h1C: ascii_o = 8'h61; // a
         8'h32: ascii_o = 8'h62; // b
         8'h21: ascii_o = 8'h63; // c
         8'h23: ascii_o = 8'h64; // d
         8'h24: ascii_o = 8'h65; // e
         8'h2B: ascii_o = 8'h66; // f
         8'h34: ascii_o = 8'h67; // g
         8'h33: ascii_o = 8'h68; // h
         8'h43: ascii_o = 8'h69; // i
         8'h3B: ascii_o = 8'h6A; // j
         8'h42: ascii_o = 8'h6B; // k
         8'h4B: ascii_o = 8'h6C; // l
         8'h3A: ascii_o = 8'h6D; // m
         8'h31: ascii_o = 8'h6E; // n
         8'h44: ascii_o = 8'h6F; // o
         8'h4D: ascii_o = 8'h70; // p
         8'h15: ascii_o = 8'h71; // q
         8'h2D: ascii_o = 8'h72; // r
         8'h1B: ascii_o = 8'h73; // s
         8'h2C: ascii_o = 8'h74; // t
         8'h3C: ascii_o = 8'h75; // u
         8'h2A: ascii_o = 8'h76; // v
         8'h1D: ascii_o = 8'h77; // w
         8'h22: ascii_o = 8'h78; // x
         8'h35: ascii_o = 8'h79; // y
         8'h1A: ascii_o = 8'h7A; // z
         8'h45: ascii_o = 8'h30; // 0
         8'h16: ascii_o = 8'h31; // 1
         8'h1E: ascii_o = 8'h32; // 2
         8'h26: ascii_o = 8'h33; // 3
         8'h25: ascii_o = 8'h34; // 4
         8'h2E: ascii_o = 8'h35; // 5
         8'h36: ascii_o = 8'h36; // 6
         8'h3D: ascii_o = 8'h37; // 7
         8'h3E: ascii_o = 8'h38; // 8
         8'h46: ascii_o = 8'h39; // 9
         8'h29: ascii_o = 8'h20; // space
         default: ascii_o = 8'h00;
      endcase
   end

endmodule
`endif

// File: rtl/ps2_key_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_key_ctrl
// Drains the ps2_keyboard FIFO one byte per 3 clocks (IDLE/ACK/GAP) and
// folds set-2 bytes (make, F0 break prefix, E0 extended prefix) into single
// key events. Tracks the held key, flags typematic repeats, counts non-repeat
// makes and latches receiver overflow.
// Optional feature macro: PS2_ASCII_EN adds the registered `ascii` output.
// Ports:
//   clk, clrn         : clock, asynchronous active-low reset
//   ps2_data_in       : FIFO head byte
//   ps2_ready         : FIFO non-empty
//   ps2_overflow      : receiver overflow indication
//   nextdata_n        : active-low pop strobe (low only in ACK)
//   key_code/ext/release/repeat : fields of the last completed event
//   key_valid         : one-cycle pulse when the fields above update
//   key_down          : a key is currently held
//   press_count       : non-repeat make counter, wraps mod 2^CNT_W
//   err_clr, err_ovf  : sticky overflow flag and its synchronous clear
//   ascii             : (PS2_ASCII_EN only) ASCII of the last event code
// ----------------------------------------------------------------------------
module ps2_key_ctrl
   import ps2_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [7:0]       ps2_data_in,
   input  logic             ps2_ready,
   input  logic             ps2_overflow,
   output logic             nextdata_n,
   output logic [7:0]       key_code,
   output logic             key_ext,
   output logic             key_release,
   output logic             key_repeat,
   output logic             key_valid,
   output logic             key_down,
   output logic [CNT_W-1:0] press_count,
   output logic             err_ovf,
   input  logic             err_clr
`ifdef PS2_ASCII_EN
   ,output logic [7:0]      ascii
`endif
);

   ps2_state_e       state_q, state_d;
   logic             brk_pend_q, brk_pend_d;
   logic             ext_pend_q, ext_pend_d;
   logic [7:0]       key_code_q, key_code_d;
   logic             key_ext_q, key_ext_d;
   logic             key_release_q, key_release_d;
   logic             key_repeat_q, key_repeat_d;
   logic             key_valid_q, key_valid_d;
   logic [7:0]       held_code_q, held_code_d;
   logic             held_ext_q, held_ext_d;
   logic             held_down_q, held_down_d;
   logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
   logic             err_ovf_q, err_ovf_d;
   logic             capture;
   logic             held_match;

`ifdef PS2_ASCII_EN
   logic [7:0]       ascii_q, ascii_d;
   logic [7:0]       lut_ascii;

   ps2_scan2ascii u_scan2ascii (
      .code_i  (ps2_data_in),
      .ascii_o (lut_ascii)
   );
`endif

   // A byte is taken only from IDLE; GAP ignores ready so the receiver read
   // pointer has settled after the pop before the head byte is looked at.
   assign capture    = (state_q == IDLE) && ps2_ready;
   assign held_match = held_down_q && (ps2_data_in == held_code_q) &&
                       (ext_pend_q == held_ext_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ps2_ready) state_d = ACK;
         ACK:     state_d = GAP;
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      brk_pend_d    = brk_pend_q;
      ext_pend_d    = ext_pend_q;
      key_code_d    = key_code_q;
      key_ext_d     = key_ext_q;
      key_release_d = key_release_q;
      key_repeat_d  = key_repeat_q;
      key_valid_d   = 1'b0;
      held_code_d   = held_code_q;
      held_ext_d    = held_ext_q;
      held_down_d   = held_down_q;
      press_cnt_d   = press_cnt_q;
`ifdef PS2_ASCII_EN
      ascii_d       = ascii_q;
`endif

      if (capture) begin
         if (ps2_data_in == PS2_BREAK) begin
            brk_pend_d = 1'b1;
         end else if (ps2_data_in == PS2_EXT) begin
            ext_pend_d = 1'b1;
         end else begin
            key_code_d    = ps2_data_in;
            key_ext_d     = ext_pend_q;
            key_release_d = brk_pend_q;
            key_valid_d   = 1'b1;
            brk_pend_d    = 1'b0;
            ext_pend_d    = 1'b0;
`ifdef PS2_ASCII_EN
            ascii_d       = ext_pend_q ? 8'h00 : lut_ascii;
`endif
            if (brk_pend_q) begin
               key_repeat_d = 1'b0;
               if (held_match) held_down_d = 1'b0;
            end else if (held_match) begin
               // Typematic repeat of the key already held: flag it, don't count.
               key_repeat_d = 1'b1;
            end else begin
               key_repeat_d = 1'b0;
               held_code_d  = ps2_data_in;
               held_ext_d   = ext_pend_q;
               held_down_d  = 1'b1;
               press_cnt_d  = press_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // Set has priority over clear so an overflow is never lost.
   always_comb begin
      err_ovf_d = err_ovf_q;
      if (ps2_overflow)  err_ovf_d = 1'b1;
      else if (err_clr)  err_ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q       <= IDLE;
         brk_pend_q    <= 1'b0;
         ext_pend_q    <= 1'b0;
         key_code_q    <= 8'h00;
         key_ext_q     <= 1'b0;
         key_release_q <= 1'b0;
         key_repeat_q  <= 1'b0;
         key_valid_q   <= 1'b0;
         held_code_q   <= 8'h00;
         held_ext_q    <= 1'b0;
         held_down_q   <= 1'b0;
         press_cnt_q   <= '0;
         err_ovf_q     <= 1'b0;
`ifdef PS2_ASCII_EN
         ascii_q       <= 8'h00;
`endif
      end else begin
         state_q       <= state_d;
         brk_pend_q    <= brk_pend_d;
         ext_pend_q    <= ext_pend_d;
         key_code_q    <= key_code_d;
         key_ext_q     <= key_ext_d;
         key_release_q <= key_release_d;
         key_repeat_q  <= key_repeat_d;
         key_valid_q   <= key_valid_d;
         held_code_q   <= held_code_d;
         held_ext_q    <= held_ext_d;
         held_down_q   <= held_down_d;
         press_cnt_q   <= press_cnt_d;
         err_ovf_q     <= err_ovf_d;
`ifdef PS2_ASCII_EN
         ascii_q       <= ascii_d;
`endif
      end
   end

   assign nextdata_n  = (state_q != ACK);
   assign key_code    = key_code_q;
   assign key_ext     = key_ext_q;
   assign key_release = key_release_q;
   assign key_repeat  = key_repeat_q;
   assign key_valid   = key_valid_q;
   assign key_down    = held_down_q;
   assign press_count = press_cnt_q;
   assign err_ovf     = err_ovf_q;
`ifdef PS2_ASCII_EN
   assign ascii       = ascii_q;
`endif

endmodule
